dco_phase_loop_filter: RTL and testbench

//  Digital phase-error detector and PI loop filter downstream of the DCO phase sampler.
//  - Takes the sampled DCO phase (units of stage delays, 2*NUM_STAGES per DCO cycle) once per refclk edge.
//  - Compares it against an accumulated target phase and produces the saturated DCO control word dctrl.
//  - Also flags lock.

---
 rtl/pll_pkg.sv | 25 ++
 rtl/phase_lock_detect.sv | 55 +++++
 rtl/dco_phase_loop_filter.sv | 122 ++++++++++++
 tb/tb_dco_phase_loop_filter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared types, defaults and the saturation helper for the DCO phase loop filter.
package pll_pkg;

  localparam int NUM_STAGES_DEFAULT = 5;

  typedef int signed dctrl_t;

  typedef enum logic [1:0] {
    ALIGN  = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } lf_state_t;

  // Symmetric clamp of a signed value to [-lim, lim].
  function automatic dctrl_t sat_int(input int val, input int lim);
    if (val > lim) begin
      return lim;
    end
    if (val < -lim) begin
      return -lim;
    end
    return val;
  endfunction

endpackage

// File: rtl/phase_lock_detect.sv
// Lock detector: counts consecutive in-tolerance phase errors and raises a
// registered lock flag once the run length has saturated.
module phase_lock_detect #(
  parameter int LOCK_TOL   = 4,
  parameter int LOCK_CNT   = 16,
  parameter int LOCK_CNT_W = $clog2(LOCK_CNT + 1)
) (
  input  logic                  refclk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic signed [31:0]    err,
  output logic                  in_tol,
  output logic [LOCK_CNT_W-1:0] lock_cnt,
  output logic                  locked
);

  localparam logic [LOCK_CNT_W-1:0] CNT_MAX = LOCK_CNT_W'(LOCK_CNT);

  logic [LOCK_CNT_W-1:0] lock_cnt_d, lock_cnt_q;
  logic                  locked_d, locked_q;

  // In-tolerance test and next count / lock flag; frozen while not enabled (ALIGN).
  always_comb begin
    in_tol     = (err <= LOCK_TOL) && (err >= -LOCK_TOL);
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (en) begin
      if (clr || !in_tol) begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end else begin
        if (lock_cnt_q != CNT_MAX) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
        locked_d = (lock_cnt_q == CNT_MAX);
      end
    end
  end

  // Counter and lock flag registers.
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign lock_cnt = lock_cnt_q;
  assign locked   = locked_q;

endmodule

// File: rtl/dco_phase_loop_filter.sv
// DCO phase-error detector and PI loop filter.
// Optional feature macro: BRAKE_EN adds the brake input, which lowers the
// target phase increment by BRAKE_DIV per edge and suppresses lock.
//
// state  | meaning
// ALIGN  | first edge after reset: seed target phase from the sampled DCO phase
// TRACK  | PI filter running, not yet locked
// LOCKED | PI filter running, lock run length reached
module dco_phase_loop_filter
  import pll_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEFAULT,
  parameter int KP_SHIFT   = 2,
  parameter int KI_SHIFT   = 6,
  parameter int ERR_MAX    = 4096,
  parameter int DCTRL_MAX  = 200000,
  parameter int LOCK_TOL   = 4,
  parameter int LOCK_CNT   = 16,
  parameter int BRAKE_DIV  = 100
) (
  input  logic               refclk,
  input  logic               reset,
  input  logic signed [31:0] divn,
  input  logic signed [31:0] dco_phase,
`ifdef BRAKE_EN
  input  logic               brake,
`endif
  output logic signed [31:0] dctrl,
  output logic signed [31:0] phase_err,
  output logic               locked
);

  localparam int LOCK_CNT_W = $clog2(LOCK_CNT + 1);

  lf_state_t state_d, state_q;
  dctrl_t    targ_d, targ_q;
  dctrl_t    integ_d, integ_q;
  dctrl_t    dctrl_d, dctrl_q;
  dctrl_t    err_d, err_q;
  dctrl_t    ftarg;
  dctrl_t    err_raw;
  dctrl_t    err_c;
  logic      brake_act;
  logic      run_en;
  logic      in_tol;
  logic [LOCK_CNT_W-1:0] lock_cnt;

`ifdef BRAKE_EN
  assign brake_act = brake;
`else
  assign brake_act = 1'b0;
`endif

  assign run_en = (state_q != ALIGN);

  // Target increment, wrapping phase error, PI update and next state.
  always_comb begin
    ftarg = (2 * NUM_STAGES) * divn;
    if (brake_act) begin
      ftarg = ftarg - BRAKE_DIV;
    end
    err_raw = targ_q - dco_phase;
    err_c   = sat_int(err_raw, ERR_MAX);

    state_d = state_q;
    targ_d  = targ_q;
    integ_d = integ_q;
    dctrl_d = dctrl_q;
    err_d   = err_q;

    if (state_q == ALIGN) begin
      targ_d  = dco_phase + ftarg;
      state_d = TRACK;
    end else begin
      targ_d  = targ_q + ftarg;
      integ_d = sat_int(integ_q + (err_c >>> KI_SHIFT), DCTRL_MAX);
      dctrl_d = sat_int(integ_d + (err_c >>> KP_SHIFT), DCTRL_MAX);
      err_d   = err_c;
      if (!brake_act && in_tol && (lock_cnt == LOCK_CNT_W'(LOCK_CNT))) begin
        state_d = LOCKED;
      end else begin
        state_d = TRACK;
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state_q <= ALIGN;
      targ_q  <= 0;
      integ_q <= 0;
      dctrl_q <= 0;
      err_q   <= 0;
    end else begin
      state_q <= state_d;
      targ_q  <= targ_d;
      integ_q <= integ_d;
      dctrl_q <= dctrl_d;
      err_q   <= err_d;
    end
  end

  phase_lock_detect #(
    .LOCK_TOL   (LOCK_TOL),
    .LOCK_CNT   (LOCK_CNT),
    .LOCK_CNT_W (LOCK_CNT_W)
  ) u_lock (
    .refclk   (refclk),
    .reset    (reset),
    .en       (run_en),
    .clr      (brake_act),
    .err      (err_c),
    .in_tol   (in_tol),
    .lock_cnt (lock_cnt),
    .locked   (locked)
  );

  assign dctrl     = dctrl_q;
  assign phase_err = err_q;

endmodule

// File: tb/tb_dco_phase_loop_filter.sv
// Directed bench for dco_phase_loop_filter; brake steps only when BRAKE_EN is defined.
module tb_dco_phase_loop_filter;

  logic               refclk = 1'b0;
  logic               reset  = 1'b1;
  logic signed [31:0] divn   = 32'sd40;
  logic signed [31:0] dco_phase = '0;
`ifdef BRAKE_EN
  logic               brake  = 1'b0;
`endif
  logic signed [31:0] dctrl;
  logic signed [31:0] phase_err;
  logic               locked;

  int n_tests = 0;
  int n_fail  = 0;
  int dco;
  int targ;

  always #5 refclk = ~refclk;

  dco_phase_loop_filter dut (
    .refclk    (refclk),
    .reset     (reset),
    .divn      (divn),
    .dco_phase (dco_phase),
`ifdef BRAKE_EN
    .brake     (brake),
`endif
    .dctrl     (dctrl),
    .phase_err (phase_err),
    .locked    (locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_dctrl", dctrl, 0);
    chk("rst_err", phase_err, 0);
    chk("rst_locked", {31'b0, locked}, 0);
    @(negedge refclk);
    @(negedge refclk);
    reset = 1'b0;
  endtask

  int slow_exp [8] = '{2, 5, 7, 10, 12, 15, 18, 22};

  initial begin
    // reset state
    #23;
    chk("reset_dctrl", dctrl, 0);
    chk("reset_err", phase_err, 0);
    chk("reset_locked", {31'b0, locked}, 0);
    @(negedge refclk);
    reset = 1'b0;

    // ideal tracking: matched at ALIGN, lock after 17 TRACK edges
    dco = 1000; dco_phase = dco;
    step();
    chk("align_dctrl", dctrl, 0);
    for (int k = 1; k <= 17; k++) begin
      dco += 400; dco_phase = dco;
      step();
      chk("ideal_err", phase_err, 0);
      chk("ideal_dctrl", dctrl, 0);
      chk("ideal_locked", {31'b0, locked}, (k == 17) ? 1 : 0);
    end
    // |err| == LOCK_TOL keeps lock
    dco += 396; dco_phase = dco;
    step();
    chk("tol_err", phase_err, 4);
    chk("tol_dctrl", dctrl, 1);
    chk("tol_locked", {31'b0, locked}, 1);
    // reset while locked
    pulse_reset();

    // wrap across 2^31
    dco = 2147483448; dco_phase = dco;
    step();
    for (int k = 1; k <= 17; k++) begin
      dco += 400; dco_phase = dco;
      step();
      chk("wrap_err", phase_err, 0);
      chk("wrap_locked", {31'b0, locked}, (k == 17) ? 1 : 0);
    end
    // |err| == LOCK_TOL+1 drops lock, negative arithmetic shifts
    dco += 405; dco_phase = dco;
    step();
    chk("drop_err", phase_err, -5);
    chk("drop_dctrl", dctrl, -3);
    chk("drop_locked", {31'b0, locked}, 0);
    dco += 395; dco_phase = dco;
    step();
    chk("after_drop_err", phase_err, 0);
    chk("after_drop_dctrl", dctrl, -1);
    chk("after_drop_locked", {31'b0, locked}, 0);
    pulse_reset();

    // slow DCO: 390 per edge
    dco = 0; dco_phase = dco;
    step();
    for (int k = 1; k <= 8; k++) begin
      dco += 390; dco_phase = dco;
      step();
      chk("slow_err", phase_err, 10 * k);
      chk("slow_dctrl", dctrl, slow_exp[k-1]);
      chk("slow_locked", {31'b0, locked}, 0);
    end
    pulse_reset();

    // frozen DCO: error clamp and output saturation
    dco = 5000; dco_phase = dco;
    step();
    targ = dco + 400;
    for (int k = 1; k <= 3300; k++) begin
      step();
      targ += 400;
      if (k == 1)    chk("sat_dctrl_k1", dctrl, 106);
      if (k == 2)    chk("sat_dctrl_k2", dctrl, 218);
      if (k == 10)   chk("sat_err_k10", phase_err, 4000);
      if (k == 11)   chk("sat_err_k11", phase_err, 4096);
      if (k == 3200) chk("sat_dctrl_k3200", dctrl, 200000);
    end
    chk("sat_dctrl_hold", dctrl, 200000);
    chk("sat_err_hold", phase_err, 4096);
    chk("sat_locked", {31'b0, locked}, 0);
    // integrator must sit exactly at the clamp: one full negative error
    dco_phase = targ + 10000;
    step();
    chk("antiwindup_err", phase_err, -4096);
    chk("antiwindup_dctrl", dctrl, 198912);
    pulse_reset();
    // no stale integrator after reset
    dco = 0; dco_phase = dco;
    step();
    dco += 400; dco_phase = dco;
    step();
    chk("post_rst_dctrl", dctrl, 0);
    chk("post_rst_err", phase_err, 0);

`ifdef BRAKE_EN
    pulse_reset();
    dco = 0; dco_phase = dco;
    step();
    for (int k = 1; k <= 17; k++) begin
      dco += 400; dco_phase = dco;
      step();
    end
    chk("brake_pre_locked", {31'b0, locked}, 1);
    brake = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      dco += 400; dco_phase = dco;
      step();
      chk("brake_err", phase_err, -100 * (k - 1));
      chk("brake_locked", {31'b0, locked}, 0);
    end
    brake = 1'b0;
    dco += 400; dco_phase = dco;
    step();
    chk("brake_release_err", phase_err, -1000);
    chk("brake_release_neg", {31'b0, dctrl[31]}, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
